vec_inst_issue_queue: RTL

Instruction buffer between the scalar processor and the vector valid/ready controller. Accepts vector instructions with their two scalar operands from the scalar processor into a DEPTH-entry FIFO. Issues them one at a time to the controller. Each issue waits for the controller's completion acknowledge before the next is offered, so at most one instruction is in flight.

---
 rtl/vec_inst_issue_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vec_inst_issue_queue.sv
// Vector instruction issue queue: DEPTH-entry FIFO with a one-in-flight issue FSM.
// Optional same-cycle bypass into an empty idle queue when VEC_IQ_BYPASS_EN is defined.
module vec_inst_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sp_inst_valid,
  output logic                       sp_inst_ready,
  input  logic [INSTR_W-1:0]         sp_instr,
  input  logic [DATA_W-1:0]          sp_rs1,
  input  logic [DATA_W-1:0]          sp_rs2,
  output logic                       inst_valid,
  input  logic                       vec_pro_ready,
  input  logic                       vec_pro_ack,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [DATA_W-1:0]          rs1_out,
  output logic [DATA_W-1:0]          rs2_out,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic                       q_empty,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0]  rs1_mem   [DEPTH];
  logic [DATA_W-1:0]  rs2_mem   [DEPTH];

  logic byp_act;
  logic hs;
  logic push;
  logic pop;
  logic byp_issue;

  assign sp_inst_ready = !full_q;
  assign q_count       = count_q;
  assign q_full        = full_q;
  assign q_empty       = empty_q;

`ifdef VEC_IQ_BYPASS_EN
  // Bypass window: idle, nothing queued, and a new instruction on offer.
  assign byp_act = (state_q == IDLE) && empty_q && sp_inst_valid;
`else
  assign byp_act = 1'b0;
`endif

  // Issue FSM next state and handshake-facing outputs.
  always_comb begin
    state_d    = state_q;
    inst_valid = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        inst_valid = !empty_q || byp_act;
        if (inst_valid && vec_pro_ready) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (vec_pro_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs        = inst_valid && vec_pro_ready;
  assign byp_issue = hs && byp_act;
  assign pop       = hs && !byp_act;
  assign push      = sp_inst_valid && sp_inst_ready
                     && !flush && !byp_issue;

  // Presented data: head entry (or bypassed offer) while valid, else zero.
  always_comb begin
    instr_out = '0;
    rs1_out   = '0;
    rs2_out   = '0;
    if (inst_valid) begin
      if (byp_act) begin
        instr_out = sp_instr;
        rs1_out   = sp_rs1;
        rs2_out   = sp_rs2;
      end else begin
        instr_out = instr_mem[rd_ptr_q];
        rs1_out   = rs1_mem[rd_ptr_q];
        rs2_out   = rs2_mem[rd_ptr_q];
      end
    end
  end

  // Pointer, occupancy and flag next state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; contents are only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= sp_instr;
      rs1_mem[wr_ptr_q]   <= sp_rs1;
      rs2_mem[wr_ptr_q]   <= sp_rs2;
    end
  end

endmodule
